// File: rtl/ctr_pr_pkg.sv
// Shared constants and the LFSR tap table for the ctr_pr family of counters.
// The tap table covers widths 4..7.
package ctr_pr_pkg;

  localparam int unsigned PR_W_MIN = 4;
  localparam int unsigned PR_W_MAX = 7;

  // Fibonacci shift-left taps; bit i set means lfsr[i] feeds the XOR.
  function automatic logic [PR_W_MAX-1:0] taps(input int unsigned w);
    logic [PR_W_MAX-1:0] mask;
    mask = '0;
    case (w)
      4:       mask = 7'b000_1100;
      5:       mask = 7'b001_0100;
      6:       mask = 7'b011_0000;
      7:       mask = 7'b110_0000;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ctr_pr_core.sv
// Maximal-length LFSR that advances on inc and can be reseeded with ld.
// A zero reseed value is replaced by 1 so the lock-up state is never entered.
module ctr_pr_core
  import ctr_pr_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         ld,
  input  logic [W-1:0] seed,
  output logic [W-1:0] out
);

  localparam logic [PR_W_MAX-1:0] TapsFull = taps(W);
  localparam logic [W-1:0]        TapMask  = TapsFull[W-1:0];

  logic [W-1:0] lfsr_q, lfsr_d;
  logic         fb;

  assign fb = ^(lfsr_q & TapMask);

  always_comb begin
    lfsr_d = lfsr_q;
    if (ld) begin
      lfsr_d = (seed == '0) ? {{(W-1){1'b0}}, 1'b1} : seed;
    end else if (inc) begin
      lfsr_d = {lfsr_q[W-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/ctr_pr_arb.sv
// Round-robin arbiter sharing one pseudo-random counter among NREQ requesters.
// The winner samples out in its ack cycle; the counter advances once per grant.
module ctr_pr_arb
  import ctr_pr_pkg::*;
#(
  parameter int unsigned  W    = 4,
  parameter int unsigned  NREQ = 4,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [2:0]      gnt_id,
  output logic [W-1:0]    out,
  input  logic            ld,
  input  logic [W-1:0]    seed,
  output logic            busy
);

  localparam int unsigned PtrW = 3;

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;
  logic            inc;

  // Search upward from rr_ptr; reset and reseed both suppress the grant.
  always_comb begin
    ack    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PtrW'((rr_ptr_q + k) % NREQ);
      if (!found && rst_n && !ld && req[idx]) begin
        found    = 1'b1;
        ack[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  assign inc  = |ack;
  assign busy = |req;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (inc) begin
      rr_ptr_d = (gnt_id == PtrW'(NREQ - 1)) ? '0 : gnt_id + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  ctr_pr_core #(
    .W    (W),
    .SEED (SEED)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .ld    (ld),
    .seed  (seed),
    .out   (out)
  );

endmodule

// File: tb/tb_ctr_pr_arb.sv
// Scoreboard bench for ctr_pr_arb: a polynomial/round-robin model queues the
// expected per-cycle response, and a negedge monitor pops and compares it.
module tb_ctr_pr_arb;

  localparam int unsigned W    = 4;
  localparam int unsigned NREQ = 4;
  localparam logic [3:0]  SEED = 4'd1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic [2:0] gnt_id;
  logic [3:0] out;
  logic       ld;
  logic [3:0] seed;
  logic       busy;

  always #5 clk = ~clk;

  ctr_pr_arb #(
    .W    (W),
    .NREQ (NREQ),
    .SEED (SEED)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .ack    (ack),
    .gnt_id (gnt_id),
    .out    (out),
    .ld     (ld),
    .seed   (seed),
    .busy   (busy)
  );

  typedef struct {
    int         tag;
    logic [3:0] ack;
    logic [2:0] gnt;
    logic [3:0] out;
    logic       busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: counter value, round-robin start, last winner (-1 = none).
  int m_lfsr;
  int m_ptr;
  int m_g;

  // x^4 + x^3 + 1, shifting left with the feedback entering bit 0.
  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 3) ^ (v >> 2)) & 1;
    return ((v << 1) | fb) & 15;
  endfunction

  task automatic push_expected(input int tag);
    exp_t x;
    x.tag  = tag;
    x.ack  = '0;
    x.gnt  = '0;
    x.out  = 4'(m_lfsr);
    x.busy = |req;
    m_g    = -1;
    if (rst_n && !ld) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        int i;
        i = (m_ptr + k) % int'(NREQ);
        if (m_g < 0 && req[i]) m_g = i;
      end
    end
    if (m_g >= 0) begin
      x.ack[m_g] = 1'b1;
      x.gnt      = 3'(m_g);
    end
    q.push_back(x);
  endtask

  task automatic update_model();
    if (!rst_n) return;
    if (ld) begin
      m_lfsr = (seed == 4'd0) ? 1 : int'(seed);
    end else if (m_g >= 0) begin
      m_lfsr = lfsr_next(m_lfsr);
      m_ptr  = (m_g + 1) % int'(NREQ);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic [3:0] r, input logic l, input logic [3:0] s, input int tag);
    req  = r;
    ld   = l;
    seed = s;
    push_expected(tag);
    @(posedge clk);
    update_model();
    #1;
  endtask

  // Reset asserted mid-cycle with requests live; checked before any clock edge.
  task automatic do_reset(input logic [3:0] r, input int tag);
    rst_n  = 1'b0;
    req    = r;
    ld     = 1'b0;
    m_lfsr = int'(SEED);
    m_ptr  = 0;
    push_expected(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (ack !== e.ack || gnt_id !== e.gnt || out !== e.out || busy !== e.busy) begin
        errors++;
        $display("FAIL scen%0d t=%0t: got ack=%b gnt_id=%0d out=%0d busy=%b, want ack=%b gnt_id=%0d out=%0d busy=%b",
                 e.tag, $time, ack, gnt_id, out, busy, e.ack, e.gnt, e.out, e.busy);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    ld     = 1'b0;
    seed   = '0;
    m_lfsr = int'(SEED);
    m_ptr  = 0;
    m_g    = -1;
    @(posedge clk);
    #1;
    push_expected(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single requester, expect 1,2,4,9,3,6,13
    repeat (7) step(4'b0001, 1'b0, 4'd0, 1);

    // 2: all requesting from reset
    do_reset(4'b1111, 2);
    repeat (8) step(4'b1111, 1'b0, 4'd0, 2);

    // 3: rr_ptr=1, then alternating pair
    do_reset(4'b0000, 3);
    step(4'b0001, 1'b0, 4'd0, 3);
    repeat (3) step(4'b0101, 1'b0, 4'd0, 3);

    // 4: reseed wins over grant; zero seed maps to 1
    step(4'b0001, 1'b1, 4'd0, 4);
    step(4'b0001, 1'b0, 4'd0, 4);
    step(4'b0001, 1'b1, 4'd7, 4);
    step(4'b0001, 1'b0, 4'd0, 4);

    // 5: full period plus wrap
    do_reset(4'b0000, 5);
    repeat (16) step(4'b0001, 1'b0, 4'd0, 5);

    // 6: reset asserted mid-stream
    repeat (3) step(4'b0011, 1'b0, 4'd0, 6);
    do_reset(4'b0011, 6);
    repeat (2) step(4'b0011, 1'b0, 4'd0, 6);

    // Random traffic with occasional reseeds
    repeat (300) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)), 7);
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
